// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch and decode stages of the 16-bit CPU.
package cpu_pkg;

    localparam int          PC_W      = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  OP_HLT    = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [15:0]     instr;
        logic [PC_W-1:0] pc;
        logic            valid;
    } ifid_t;

    function automatic logic is_hlt(input logic [15:0] word);
        return word[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load, hold on stall, or squash to a NOP bubble
// while keeping the last pc.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_hold,
    input  logic  i_squash,
    input  ifid_t i_next,
    output ifid_t o_q
);

    ifid_t r_q;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
        end else if (i_squash) begin
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (!i_hold) begin
            r_q <= i_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// and feeds decode through the IF/ID register with stall, redirect and HLT.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            valid,
    output logic            halted
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_pend_valid;
    logic            w_hlt_in;
    logic            w_squash;
    ifid_t           w_ifid_next;
    ifid_t           w_ifid_q;

    assign w_hlt_in = r_pend_valid && is_hlt(imem_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        if (redirect)
            w_state_next = ST_RUN;
        else if (!stall && r_state == ST_RUN && w_hlt_in)
            w_state_next = ST_HALT;
    end

    always_comb begin
        imem_rd = redirect || (r_state == ST_RUN);
        halted  = (r_state == ST_HALT);
    end

    // While stalled, re-read the pending address so its data is still on
    // imem_data when the stall releases.
    always_comb begin
        imem_addr = r_fetch_pc;
        if (redirect)
            imem_addr = redirect_pc;
        else if (stall)
            imem_addr = r_pend_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_pend_valid <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc   <= redirect_pc + 1'b1;
            r_pend_pc    <= redirect_pc;
            r_pend_valid <= 1'b1;
        end else if (!stall && r_state == ST_RUN) begin
            r_fetch_pc   <= r_fetch_pc + 1'b1;
            r_pend_pc    <= r_fetch_pc;
            r_pend_valid <= !w_hlt_in;
        end
    end

    assign w_ifid_next = '{
        instr: r_pend_valid ? imem_data : NOP_INSTR,
        pc:    r_pend_pc,
        valid: r_pend_valid
    };

    assign w_squash = redirect || (r_state == ST_HALT && !stall);

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (stall),
        .i_squash (w_squash),
        .i_next   (w_ifid_next),
        .o_q      (w_ifid_q)
    );

    assign instr = w_ifid_q.instr;
    assign pc    = w_ifid_q.pc;
    assign valid = w_ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, HLT,
// redirect+stall, PC wrap and mid-run reset, against hand-computed values.
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          hlt_addr = -1;

    // DUT 1: RESET_PC = 0
    logic        rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr, imem_data = 16'h0000, instr, pc;
    logic        imem_rd, valid, halted;

    // DUT 2: RESET_PC = FFFE, no stalls or redirects
    logic        rst_n2 = 1'b0;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;
    logic [15:0] imem_addr2, imem_data2 = 16'h0000, instr2, pc2;
    logic        imem_rd2, valid2, halted2;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .instr(instr), .pc(pc), .valid(valid),
        .halted(halted)
    );

    if_stage #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n2), .stall(zero1), .redirect(zero1),
        .redirect_pc(zero16), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .imem_data(imem_data2), .instr(instr2), .pc(pc2), .valid(valid2),
        .halted(halted2)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a, input int hlt);
        logic [15:0] base;
        base = 16'h1000;
        if (hlt >= 0 && int'(a) == hlt) return 16'hF000;
        return base + a;
    endfunction

    // Synchronous-read instruction memory models, 1-cycle latency
    always @(posedge clk) begin
        if (imem_rd)  imem_data  <= mem_word(imem_addr, hlt_addr);
        if (imem_rd2) imem_data2 <= mem_word(imem_addr2, -1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_instr,
                             input logic [15:0] e_pc, input logic e_valid);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".pc"},    pc,    e_pc);
        check({tag, ".valid"}, {15'd0, valid}, {15'd0, e_valid});
    endtask

    task automatic check_out2(input string tag, input logic [15:0] e_instr,
                              input logic [15:0] e_pc, input logic e_valid);
        check({tag, ".instr"}, instr2, e_instr);
        check({tag, ".pc"},    pc2,    e_pc);
        check({tag, ".valid"}, {15'd0, valid2}, {15'd0, e_valid});
    endtask

    initial begin
        // Reset state
        tick(); tick(); #1;
        check_out("rst", 16'h0000, 16'h0000, 1'b0);
        check("rst.halted", {15'd0, halted}, 16'd0);
        check("rst.imem_rd", {15'd0, imem_rd}, 16'd1);
        check("rst.addr", imem_addr, 16'h0000);

        // Sequential fetch after release: one bubble, then mem[a] in order
        rst_n = 1'b1; #1;
        check("seq.addr0", imem_addr, 16'h0000);
        tick(); check("seq.bubble.valid", {15'd0, valid}, 16'd0);
        tick(); check_out("seq0", 16'h1000, 16'h0000, 1'b1);
        tick(); check_out("seq1", 16'h1001, 16'h0001, 1'b1);
        tick(); check_out("seq2", 16'h1002, 16'h0002, 1'b1);
        tick(); tick(); tick(); check_out("seq5", 16'h1005, 16'h0005, 1'b1);

        // Stall 3 cycles at pc=5
        stall = 1'b1; #1;
        check("stall.addr", imem_addr, 16'h0006);
        for (int i = 0; i < 3; i++) begin
            tick(); check_out("stall.hold", 16'h1005, 16'h0005, 1'b1);
        end
        stall = 1'b0;
        tick(); check_out("stall.rel6", 16'h1006, 16'h0006, 1'b1);
        tick(); check_out("stall.rel7", 16'h1007, 16'h0007, 1'b1);

        // Redirect to 0040
        redirect = 1'b1; redirect_pc = 16'h0040; #1;
        check("redir.addr", imem_addr, 16'h0040);
        tick(); check_out("redir.bubble", 16'h0000, 16'h0007, 1'b0);
        redirect = 1'b0;
        tick(); check_out("redir.tgt", 16'h1040, 16'h0040, 1'b1);
        tick(); check_out("redir.tgt1", 16'h1041, 16'h0041, 1'b1);

        // Redirect and stall together: redirect wins
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0080; #1;
        check("rs.addr", imem_addr, 16'h0080);
        tick(); check_out("rs.bubble", 16'h0000, 16'h0041, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        tick(); check_out("rs.tgt", 16'h1080, 16'h0080, 1'b1);
        tick(); check_out("rs.tgt1", 16'h1081, 16'h0081, 1'b1);

        // HLT at address 3
        hlt_addr = 3;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick(); redirect = 1'b0;
        tick(); check_out("hlt.pc0", 16'h1000, 16'h0000, 1'b1);
        tick(); tick(); check_out("hlt.pc2", 16'h1002, 16'h0002, 1'b1);
        check("hlt.pre.halted", {15'd0, halted}, 16'd0);
        tick(); check_out("hlt.hlt", 16'hF000, 16'h0003, 1'b1);
        check("hlt.halted", {15'd0, halted}, 16'd1);
        check("hlt.imem_rd", {15'd0, imem_rd}, 16'd0);
        tick(); check_out("hlt.after1", 16'h0000, 16'h0003, 1'b0);
        check("hlt.after1.halted", {15'd0, halted}, 16'd1);
        tick(); check_out("hlt.after2", 16'h0000, 16'h0003, 1'b0);
        check("hlt.after2.imem_rd", {15'd0, imem_rd}, 16'd0);

        // Redirect out of HALT
        redirect = 1'b1; redirect_pc = 16'h0010; #1;
        check("unhlt.imem_rd", {15'd0, imem_rd}, 16'd1);
        tick(); check("unhlt.halted", {15'd0, halted}, 16'd0);
        check("unhlt.bubble", {15'd0, valid}, 16'd0);
        redirect = 1'b0;
        tick(); check_out("unhlt.tgt", 16'h1010, 16'h0010, 1'b1);

        // DUT2: RESET_PC=FFFE with wrap
        rst_n2 = 1'b1; #1;
        check("wrap.addr0", imem_addr2, 16'hFFFE);
        tick(); check("wrap.bubble", {15'd0, valid2}, 16'd0);
        tick(); check_out2("wrap.fffe", 16'h0FFE, 16'hFFFE, 1'b1);
        tick(); check_out2("wrap.ffff", 16'h0FFF, 16'hFFFF, 1'b1);
        tick(); check_out2("wrap.0000", 16'h1000, 16'h0000, 1'b1);
        tick(); check_out2("wrap.0001", 16'h1001, 16'h0001, 1'b1);

        // Mid-cycle async reset
        #2 rst_n2 = 1'b0; #1;
        check_out2("mrst", 16'h0000, 16'h0000, 1'b0);
        check("mrst.halted", {15'd0, halted2}, 16'd0);
        check("mrst.addr", imem_addr2, 16'hFFFE);
        tick(); tick(); rst_n2 = 1'b1;
        tick(); check("mrst.bubble", {15'd0, valid2}, 16'd0);
        tick(); check_out2("mrst.fffe", 16'h0FFE, 16'hFFFE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
